// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, HOLD} spi_state_e;

  localparam logic SPI_OP_WR = 1'b1;
  localparam logic SPI_OP_RD = 1'b0;
endpackage

// File: rtl/spi_slave_if.sv
// SPI bus signals between master and responder; the responder's outputs are all registered.
interface spi_slave_if;
  logic ssel;
  logic mosi;
  logic rd_wr;
  logic miso;
  logic wr_done;
  logic rd_done;
  logic frame_err;

  modport master (
    output ssel, mosi, rd_wr,
    input  miso, wr_done, rd_done, frame_err
  );

  modport slave (
    input  ssel, mosi, rd_wr,
    output miso, wr_done, rd_done, frame_err
  );
endinterface

// File: rtl/spi_slave_regfile.sv
// Register file: one synchronous write port, combinational read, synchronous clear.
module spi_slave_regfile #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge sclk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata = regs[raddr];
endmodule

// File: rtl/spi_slave.sv
// SPI responder: decodes address/data frames in the sclk domain, serves reads MSB first on miso.
module spi_slave
  import spi_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic  sclk,
  input  logic  rst,
  spi_slave_if.slave bus
);
  localparam int TOTAL = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(TOTAL + 1);

  spi_state_e        state;
  logic              op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_sh;
  logic [DATA_W-1:0] rd_sh;
  logic [CNT_W-1:0]  cnt;
  logic              miso;
  logic              wr_done;
  logic              rd_done;
  logic              frame_err;

  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wr_nxt;
  logic [DATA_W-1:0] rd_word;
  logic              op_nxt;
  logic              last_addr;
  logic              wr_commit;

  // The read address includes the bit arriving this edge so the first data bit goes out immediately.
  always_comb begin
    addr_nxt  = (state == IDLE) ? ADDR_W'(bus.mosi) : ADDR_W'({addr, bus.mosi});
    wr_nxt    = DATA_W'({wr_sh, bus.mosi});
    op_nxt    = (state == IDLE) ? bus.rd_wr : op;
    last_addr = ((state == IDLE) && (ADDR_W == 1)) ||
                ((state == ADDR) && (cnt == CNT_W'(ADDR_W - 1)));
    wr_commit = (state == WDATA) && !bus.ssel && (cnt == CNT_W'(TOTAL - 1));
  end

  spi_slave_regfile #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_regfile (
    .sclk  (sclk),
    .rst   (rst),
    .we    (wr_commit),
    .waddr (addr),
    .wdata (wr_nxt),
    .raddr (addr_nxt),
    .rdata (rd_word)
  );

  always_ff @(posedge sclk) begin
    if (rst) begin
      state     <= IDLE;
      op        <= 1'b0;
      addr      <= '0;
      wr_sh     <= '0;
      rd_sh     <= '0;
      cnt       <= '0;
      miso      <= 1'b0;
      wr_done   <= 1'b0;
      rd_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_done   <= 1'b0;
      rd_done   <= 1'b0;
      frame_err <= 1'b0;
      if (bus.ssel) begin
        // Deselect mid-frame discards everything gathered so far.
        frame_err <= (state == ADDR) || (state == WDATA) || (state == RDATA);
        state     <= IDLE;
        op        <= 1'b0;
        addr      <= '0;
        wr_sh     <= '0;
        rd_sh     <= '0;
        cnt       <= '0;
        miso      <= 1'b0;
      end else begin
        case (state)
          IDLE, ADDR: begin
            op    <= op_nxt;
            addr  <= addr_nxt;
            cnt   <= cnt + CNT_W'(1);
            state <= ADDR;
            if (last_addr) begin
              if (op_nxt == SPI_OP_RD) begin
                miso  <= rd_word[DATA_W-1];
                rd_sh <= rd_word << 1;
                state <= RDATA;
              end else begin
                state <= WDATA;
              end
            end
          end
          WDATA: begin
            if (wr_commit) begin
              wr_done <= 1'b1;
              state   <= HOLD;
            end else begin
              wr_sh <= wr_nxt;
              cnt   <= cnt + CNT_W'(1);
            end
          end
          RDATA: begin
            if (cnt == CNT_W'(TOTAL - 1)) begin
              rd_done <= 1'b1;
              miso    <= 1'b0;
              state   <= HOLD;
            end else begin
              miso  <= rd_sh[DATA_W-1];
              rd_sh <= rd_sh << 1;
              cnt   <= cnt + CNT_W'(1);
            end
          end
          HOLD:    state <= HOLD;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.miso      = miso;
  assign bus.wr_done   = wr_done;
  assign bus.rd_done   = rd_done;
  assign bus.frame_err = frame_err;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: frame-level scoreboard of per-cycle expected outputs against a register model.
module tb_spi_slave;
  import spi_pkg::*;

  typedef struct packed {
    logic miso;
    logic wr_done;
    logic rd_done;
    logic frame_err;
  } exp_t;

  logic sclk;
  logic rst;
  spi_slave_if bus ();

  spi_slave #(.ADDR_W(4), .DATA_W(8)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  exp_t       sb [$];
  logic [7:0] mem [16];
  int         checks;
  int         errors;

  task automatic step(input logic s, input logic m, input logic rw);
    bus.ssel  = s;
    bus.mosi  = m;
    bus.rd_wr = rw;
    @(posedge sclk);
    #1;
  endtask

  // Drives one frame of `low` ssel-low cycles plus the closing ssel-high cycle.
  task automatic do_frame(input string tag, input logic wr, input logic [3:0] a,
                          input logic [7:0] d, input int low);
    logic [11:0] bits;
    exp_t        e;
    exp_t        got;
    logic        b;
    bits = {a, d};
    for (int c = 1; c <= low; c++) begin
      e = '0;
      if (wr == SPI_OP_WR) begin
        e.wr_done = (c == 12);
      end else begin
        if (c >= 4 && c <= 11) e.miso = mem[a][11-c];
        e.rd_done = (c == 12);
      end
      sb.push_back(e);
    end
    e = '0;
    e.frame_err = (low < 12);
    sb.push_back(e);
    if (wr == SPI_OP_WR && low >= 12) mem[a] = d;

    for (int c = 1; c <= low + 1; c++) begin
      if (c <= low) begin
        b = (c <= 12) ? bits[12-c] : 1'($urandom_range(0, 1));
        step(1'b0, b, (c == 1) ? wr : 1'($urandom_range(0, 1)));
      end else begin
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      e   = sb.pop_front();
      got = {bus.miso, bus.wr_done, bus.rd_done, bus.frame_err};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: miso/wr_done/rd_done/frame_err got %b expected %b",
                 tag, c, got, e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if ({bus.miso, bus.wr_done, bus.rd_done, bus.frame_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {bus.miso, bus.wr_done, bus.rd_done, bus.frame_err});
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  task automatic test_write();
    do_frame("write_3_a5", SPI_OP_WR, 4'h3, 8'hA5, 12);
    checks++;
    if (dut.u_regfile.regs[3] !== 8'hA5) begin
      errors++;
      $display("FAIL regfile_3: got %h expected a5", dut.u_regfile.regs[3]);
    end
  endtask

  task automatic test_read();
    do_frame("read_3", SPI_OP_RD, 4'h3, 8'h00, 12);
    do_frame("read_f_unwritten", SPI_OP_RD, 4'hF, 8'h00, 12);
  endtask

  task automatic test_abort();
    do_frame("abort_write_5", SPI_OP_WR, 4'h5, 8'hFF, 6);
    do_frame("read_5_after_abort", SPI_OP_RD, 4'h5, 8'h00, 12);
    do_frame("abort_read_3", SPI_OP_RD, 4'h3, 8'h00, 7);
  endtask

  task automatic test_hold();
    do_frame("write_7_hold", SPI_OP_WR, 4'h7, 8'h3C, 17);
    do_frame("read_7_after_hold", SPI_OP_RD, 4'h7, 8'h00, 12);
  endtask

  task automatic test_reset_mid_frame();
    logic [11:0] bits;
    bits = {4'h2, 8'h5A};
    for (int c = 1; c <= 8; c++) step(1'b0, bits[12-c], (c == 1) ? 1'b1 : 1'b0);
    rst = 1'b1;
    step(1'b0, bits[3], 1'b0);
    checks++;
    if ({bus.miso, bus.wr_done, bus.rd_done, bus.frame_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_frame_outputs: got %b expected 0000",
               {bus.miso, bus.wr_done, bus.rd_done, bus.frame_err});
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if ({bus.miso, bus.wr_done, bus.rd_done, bus.frame_err} !== 4'b0000) begin
      errors++;
      $display("FAIL after_reset_idle: got %b expected 0000",
               {bus.miso, bus.wr_done, bus.rd_done, bus.frame_err});
    end
    checks++;
    if (dut.u_regfile.regs[2] !== 8'h00) begin
      errors++;
      $display("FAIL regfile_2_after_reset: got %h expected 00", dut.u_regfile.regs[2]);
    end
    do_frame("read_3_after_reset", SPI_OP_RD, 4'h3, 8'h00, 12);
    do_frame("write_2_after_reset", SPI_OP_WR, 4'h2, 8'h96, 12);
    do_frame("read_2_after_reset", SPI_OP_RD, 4'h2, 8'h00, 12);
  endtask

  task automatic test_back_to_back();
    logic [3:0] a;
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      a = 4'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      do_frame("b2b_write", SPI_OP_WR, a, d, 12);
      do_frame("b2b_read", SPI_OP_RD, a, 8'h00, 12);
      do_frame("b2b_read_other", SPI_OP_RD, 4'($urandom_range(0, 15)), 8'h00, 12);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.ssel  = 1'b1;
    bus.mosi  = 1'b0;
    bus.rd_wr = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_hold();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
